// File: rtl/serial_tc_to_sm.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Takes a W_IN-bit word LSB-first and returns a saturated W_OUT-bit sign-magnitude result.
module serial_tc_to_sm #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sdin,
    output logic             ready,
    output logic [W_OUT-1:0] dout,
    output logic             valid,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    // Handshake: start is sampled only on an edge where ready=1; valid is a
    // one-cycle pulse, and dout/ovf hold their value until the next pulse.

    typedef enum logic [1:0] {IDLE, SHIFT, CONV, DONE} state_t;

    localparam int CW = $clog2(W_IN + 1);
    localparam logic [W_IN:0] MAXM = (W_IN + 1)'((1 << (W_OUT - 1)) - 1);

    state_t          state;
    state_t          next_state;
    logic [W_IN-1:0] sreg;
    logic [CW-1:0]   cnt;
    logic            last_bit;

    logic [W_IN:0]    ext;
    logic [W_IN:0]    mag;
    logic             neg;
    logic             sat;
    logic [W_OUT-1:0] conv_dout;

    assign last_bit = (cnt == CW'(W_IN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = CONV;
            CONV:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        fsm_state = state;
    end

    // Magnitude uses one extra bit so the most negative input does not wrap.
    always_comb begin
        neg = sreg[W_IN-1];
        ext = {sreg[W_IN-1], sreg};
        mag = neg ? -ext : ext;
        sat = (mag > MAXM);
        if (sat) begin
            conv_dout = {neg, {(W_OUT - 1){1'b1}}};
        end else begin
            conv_dout = {neg, mag[W_OUT-2:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            cnt   <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= (state == CONV);
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg <= {{(W_IN - 1){1'b0}}, sdin};
                        cnt  <= CW'(1);
                    end
                end
                SHIFT: begin
                    sreg[cnt] <= sdin;
                    cnt       <= cnt + CW'(1);
                end
                CONV: begin
                    dout <= conv_dout;
                    ovf  <= sat;
                    cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tc_to_sm.sv
// Bench for serial_tc_to_sm: directed and random words against an arithmetic
// reference model, plus continuous-start and mid-word reset scenarios.
module tb_serial_tc_to_sm;

    localparam int W_IN  = 8;
    localparam int W_OUT = 7;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sdin;
    logic             ready;
    logic [W_OUT-1:0] dout;
    logic             valid;
    logic             ovf;
    logic [1:0]       fsm_state;

    int n_vec;
    int n_err;

    serial_tc_to_sm #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sdin      (sdin),
        .ready     (ready),
        .dout      (dout),
        .valid     (valid),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: interpret as a signed integer, take |v|, saturate at 2^(W_OUT-1)-1.
    // Result packs {ovf, sign, magnitude}.
    function automatic logic [W_OUT:0] model(input logic [W_IN-1:0] w);
        int v;
        int mag;
        int maxm;
        logic s;
        v    = w[W_IN-1] ? int'(w) - (1 << W_IN) : int'(w);
        s    = (v < 0);
        mag  = s ? -v : v;
        maxm = (1 << (W_OUT - 1)) - 1;
        if (mag > maxm) return {1'b1, s, (W_OUT - 1)'(maxm)};
        return {1'b0, s, (W_OUT - 1)'(mag)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [W_IN-1:0] w, input bit noise);
        logic [W_OUT:0] e;
        int edges;
        e = model(w);
        @(negedge clk);
        chk("ready_idle", 32'(ready), 32'd1);
        start = 1'b1;
        sdin  = w[0];
        @(posedge clk);
        for (int i = 1; i < W_IN; i++) begin
            @(negedge clk);
            chk("ready_busy", 32'(ready), 32'd0);
            chk("valid_busy", 32'(valid), 32'd0);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            sdin  = w[i];
            @(posedge clk);
        end
        edges = W_IN - 1;
        @(negedge clk);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sdin  = 1'b0;
        while (!valid && edges < W_IN + 10) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (noise) start = 1'($urandom_range(0, 1));
        end
        chk("latency", 32'(edges), 32'(W_IN));
        chk("dout", 32'(dout), 32'(e[W_OUT-1:0]));
        chk("ovf", 32'(ovf), 32'(e[W_OUT]));
        chk("ready_done", 32'(ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("valid_pulse", 32'(valid), 32'd0);
        chk("dout_hold", 32'(dout), 32'(e[W_OUT-1:0]));
        chk("ovf_hold", 32'(ovf), 32'(e[W_OUT]));
    endtask

    initial begin
        logic [W_IN-1:0] plan[10];
        logic [W_IN-1:0] w5;
        logic [W_OUT:0]  e;
        int n_pulse;
        int last;
        int pos;
        bit saw_valid;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sdin  = 1'b0;
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        plan = '{8'h01, 8'hFF, 8'hFD, 8'h0F, 8'hF1, 8'h3F, 8'h40, 8'hC1, 8'h80, 8'h00};
        foreach (plan[i]) send_word(plan[i], 1'b0);

        for (int i = 0; i < 30; i++) send_word(W_IN'($urandom_range(0, (1 << W_IN) - 1)), 1'b1);

        // start held high: one conversion every W_IN+2 cycles
        w5      = 8'h05;
        e       = model(w5);
        n_pulse = 0;
        last    = -1;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            pos = c % (W_IN + 2);
            if (pos < W_IN) sdin = w5[pos];
            else sdin = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                n_pulse++;
                chk("hold_dout", 32'(dout), 32'(e[W_OUT-1:0]));
                chk("hold_ovf", 32'(ovf), 32'(e[W_OUT]));
                if (last >= 0) chk("hold_interval", 32'(c - last), 32'(W_IN + 2));
                last = c;
            end
        end
        start = 1'b0;
        sdin  = 1'b0;
        chk("hold_pulses", 32'(n_pulse), 32'd5);

        // mid-word reset after 4 bits of 8'hFF
        @(negedge clk);
        start = 1'b1;
        sdin  = 1'b1;
        @(posedge clk);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            sdin  = 1'b1;
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sdin  = 1'b0;
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        chk("post_rst_no_valid", 32'(saw_valid), 32'd0);
        send_word(8'hFD, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tc_to_sm.md
Name: serial_tc_to_sm

Overview:
- Bit-serial decoder: receives a W_IN-bit two's-complement word LSB-first on a 1-bit line and returns it as a W_OUT-bit sign-magnitude value.
- Saturates the result and raises an overflow flag when the magnitude does not fit.
- It is the return path of the sign-magnitude→two's-complement LED widening stage: it recovers the narrow signed-magnitude value from the wide word.
- Single clock domain; drives LEDs/downstream logic with a registered result and a one-cycle valid pulse.

Parameters:
- W_IN, 8, width of the incoming two's-complement word (bits shifted in).
- W_OUT, 7, width of the sign-magnitude output: 1 sign bit + (W_OUT-1) magnitude bits. Legal only when W_OUT <= W_IN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a word; sdin carries bit 0 in the same cycle.
- sdin  in  1  serial data, LSB first.
- ready  out  1  high only in IDLE; start is ignored when low.
- dout  out  W_OUT  sign-magnitude result: [W_OUT-1] is the sign, the rest is the magnitude.
- valid  out  1  one-cycle pulse when dout/ovf update.
- ovf  out  1  magnitude saturated; held with dout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, shift register=0, bit counter=0.
  - dout=0, valid=0, ovf=0, ready=1.
  - A partially received word is discarded; no valid pulse follows reset release.
- FSM states: IDLE, SHIFT, CONV, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: capture sdin as bit 0, counter=1, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge captures sdin into bit[counter], then increments the counter.
  - After the edge that captures bit W_IN-1, go to CONV.
  - start is ignored.
- CONV (one cycle): at its closing edge, register dout and ovf, set valid=1, go to DONE.
- DONE (one cycle): valid=1, ready=0. Next edge: valid=0, go to IDLE.
- Latency: valid is high in the cycle following the W_IN-th edge after the start-sampling edge (the 8th edge for defaults). Back-to-back words are possible every W_IN+2 cycles.
- Conversion, with w = the captured word (signed), MAXM = 2^(W_OUT-1)-1:
  - w >= 0:
    - w <= MAXM: dout = {0, w[W_OUT-2:0]}, ovf=0.
    - otherwise: dout = {0, all ones}, ovf=1.
  - w < 0: mag = -w, computed in W_IN+1 bits so that -2^(W_IN-1) does not wrap.
    - mag <= MAXM: dout = {1, mag[W_OUT-2:0]}, ovf=0.
    - otherwise: dout = {1, all ones}, ovf=1.
- Zero always yields positive zero (all bits 0); negative zero is never produced.
- dout and ovf hold their value between conversions and change only together with the valid pulse.
- A start asserted during SHIFT/CONV/DONE has no effect. It is not queued.
- Reset asserted mid-SHIFT or in CONV takes effect immediately (asynchronous), per the reset rules above.

Test Plan:
- Send 8'h01 (start + 8 bits LSB-first) → valid exactly 8 edges after the start edge; dout=7'b0000001, ovf=0. Send 8'hFF → dout=7'b1000001, ovf=0.
- Send 8'hFD → dout=7'b1000011; send 8'h0F → dout=7'b0001111; send 8'hF1 → dout=7'b1001111. All with ovf=0, one-cycle valid each, ready low during transfer.
- Overflow/boundary:
  - 8'h3F → 7'b0111111, ovf=0.
  - 8'h40 → 7'b0111111, ovf=1.
  - 8'hC1 (-63) → 7'b1111111, ovf=0.
  - 8'h80 (-128) → 7'b1111111, ovf=1.
  - 8'h00 → 7'b0000000.
- Hold start=1 continuously with the pattern of 8'h05 → exactly one conversion per W_IN+2 cycles. Extra start pulses during SHIFT/DONE are ignored; dout=7'b0000101 each time.
- Pull rst_n low after 4 bits of 8'hFF → outputs immediately 0, ready=1, no valid. A fresh 8'hFD afterwards decodes to 7'b1000011.
